// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 vector unit.
//   - opcode encodings accepted on in_op
//   - FP16 special-value constants and exponent bias
//   - FSM state encoding used by the top level
//   - lane mode select values for fp16_lane
package fp16_pkg;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam int          BIAS    = 15;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_VADD) || (op == OP_VDOT) || (op == OP_SMUL);
  endfunction

endpackage

// File: rtl/fp16_lane.sv
// One FP16 lane: purely combinational add or multiply.
//   mode : MODE_ADD -> y = a + b, MODE_MUL -> y = a * b
//   a, b : FP16 operands
//   y    : FP16 result
// Arithmetic: round-to-nearest-even, subnormal inputs read as signed zero,
// subnormal results flush to signed zero, overflow saturates to signed inf,
// every NaN-producing case returns the canonical QNAN.
module fp16_lane
  import fp16_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  function automatic logic [15:0] inf_of(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  // sig holds the hidden bit at [13], mantissa at [12:3], guard at [2],
  // round at [1] and sticky at [0]. e is the unbiased-plus-bias exponent.
  function automatic logic [15:0] pack(input logic s, input logic signed [7:0] e,
                                       input logic [13:0] sig);
    logic              up;
    logic [11:0]       m;
    logic signed [7:0] ee;
    up = sig[2] & (sig[3] | (|sig[1:0]));
    m  = {1'b0, sig[13:3]} + {11'd0, up};
    ee = e;
    if (m[11]) begin
      ee = e + 8'sd1;
      m  = m >> 1;
    end
    if (ee >= 8'sd31)     return inf_of(s);
    else if (ee <= 8'sd0) return {s, 15'd0};
    else                  return {s, ee[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] x, input logic [15:0] z);
    logic              s, zx, zz, ix, iz, nx, nz;
    logic [21:0]       p;
    logic [13:0]       sig;
    logic signed [7:0] e;
    s  = x[15] ^ z[15];
    zx = (x[14:10] == 5'd0);
    zz = (z[14:10] == 5'd0);
    ix = (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
    iz = (z[14:10] == 5'd31) && (z[9:0] == 10'd0);
    nx = (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    nz = (z[14:10] == 5'd31) && (z[9:0] != 10'd0);
    if (nx || nz)                  return QNAN;
    else if ((ix && zz) || (iz && zx)) return QNAN;
    else if (ix || iz)             return inf_of(s);
    else if (zx || zz)             return {s, 15'd0};
    p = 22'({1'b1, x[9:0]}) * 22'({1'b1, z[9:0]});
    e = 8'(x[14:10]) + 8'(z[14:10]) - 8'(BIAS);
    // Product of two 1.x significands lies in [1,4); renormalise when >= 2.
    if (p[21]) begin
      sig = {p[21:9], |p[8:0]};
      e   = e + 8'sd1;
    end else begin
      sig = {p[20:8], |p[7:0]};
    end
    return pack(s, e, sig);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] z);
    logic              zx, zz, ix, iz, nx, nz;
    logic              sx, sy;
    logic [4:0]        ex, ey, d;
    logic [9:0]        fx, fy;
    logic [13:0]       mx, my, diff, sig;
    logic [27:0]       wide;
    logic [14:0]       sum;
    logic signed [7:0] e;
    int                lz;
    logic              found;
    zx = (x[14:10] == 5'd0);
    zz = (z[14:10] == 5'd0);
    ix = (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
    iz = (z[14:10] == 5'd31) && (z[9:0] == 10'd0);
    nx = (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    nz = (z[14:10] == 5'd31) && (z[9:0] != 10'd0);
    if (nx || nz)                          return QNAN;
    else if (ix && iz && (x[15] != z[15])) return QNAN;
    else if (ix)                           return x;
    else if (iz)                           return z;
    else if (zx && zz)                     return {x[15] & z[15], 15'd0};
    else if (zx)                           return z;
    else if (zz)                           return x;
    // Order by magnitude so the aligned difference is never negative.
    if (x[14:0] >= z[14:0]) begin
      sx = x[15]; ex = x[14:10]; fx = x[9:0];
      sy = z[15]; ey = z[14:10]; fy = z[9:0];
    end else begin
      sx = z[15]; ex = z[14:10]; fx = z[9:0];
      sy = x[15]; ey = x[14:10]; fy = x[9:0];
    end
    d  = ex - ey;
    // Shifts beyond 15 leave only sticky; clamping keeps that sticky bit alive.
    if (d > 5'd15) d = 5'd15;
    mx   = {1'b1, fx, 3'b000};
    wide = {1'b1, fy, 3'b000, 14'd0} >> d;
    my   = wide[27:14] | {13'd0, |wide[13:0]};
    if (sx == sy) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[14]) begin
        sig = {sum[14:2], sum[1] | sum[0]};
        e   = 8'(ex) + 8'sd1;
      end else begin
        sig = sum[13:0];
        e   = 8'(ex);
      end
      return pack(sx, e, sig);
    end
    diff = mx - my;
    if (diff == 14'd0) return 16'h0000;
    lz    = 0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else         lz = lz + 1;
      end
    end
    // A shift of 2 or more only happens when d <= 1, where nothing was
    // lost to sticky, so shifting zeros in is exact.
    sig = diff << lz;
    e   = 8'(ex) - 8'(lz);
    return pack(sx, e, sig);
  endfunction

  always_comb begin
    y = 16'h0000;
    if (mode == MODE_MUL) y = fp_mul(a, b);
    else                  y = fp_add(a, b);
  end

endmodule

// File: rtl/vector_fp16_unit.sv
// Multi-beat FP16 vector unit: VADD, SMUL (vector times b lane 0), VDOT.
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : operation handshake; in_op/in_a/in_b sampled on accept
//   out_valid/ready: result handshake; out_result/out_err held while waiting
//   dbg_state      : current FSM state (state_t encoding)
// Handshake: a transfer occurs on a rising edge where valid and ready are
// both high; valid never depends on ready, and the producer keeps its
// payload stable until the transfer. in_ready is high only in IDLE, so a
// new operation is taken at the earliest one cycle after the output
// transfer. An accepted operation occupies LANES/LPC RUN beats, each
// working on LPC consecutive lanes; VDOT folds the products into a
// running accumulator in strict lane order.
module vector_fp16_unit
  import fp16_pkg::*;
#(
  parameter int LANES = 16,
  parameter int LPC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [LANES*16-1:0] in_a,
  input  logic [LANES*16-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*16-1:0] out_result,
  output logic                out_err,
  output logic [1:0]          dbg_state
);

  localparam int N  = LANES / LPC;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = LANES * 16;

  generate
    if ((LANES % LPC) != 0) begin : g_bad_lpc
      $error("vector_fp16_unit: LANES must be divisible by LPC");
    end
  endgenerate

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [15:0]     acc_q;
  logic [BW-1:0]   beat_q;
  logic            err_q;
  logic            accept;
  logic            last_beat;
  logic            lane_mode;

  logic [LPC-1:0][15:0] la, lb, ly;
  logic [LPC:0][15:0]   chain;

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_q == BW'(N - 1));
  assign lane_mode = (op_q == OP_VADD) ? MODE_ADD : MODE_MUL;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = op_legal(in_op) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign chain[0] = acc_q;

  genvar j;
  generate
    for (j = 0; j < LPC; j++) begin : g_lane
      assign la[j] = a_q[(int'(beat_q) * LPC + j) * 16 +: 16];
      // SMUL broadcasts the scalar held in b lane 0.
      assign lb[j] = (op_q == OP_SMUL) ? b_q[15:0]
                                       : b_q[(int'(beat_q) * LPC + j) * 16 +: 16];

      fp16_lane u_lane (
        .mode (lane_mode),
        .a    (la[j]),
        .b    (lb[j]),
        .y    (ly[j])
      );

      // Serial add chain keeps the VDOT summation order identical to a
      // lane-by-lane loop, with one rounding per add.
      fp16_lane u_acc (
        .mode (MODE_ADD),
        .a    (chain[j]),
        .b    (ly[j]),
        .y    (chain[j+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 4'd0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      acc_q  <= 16'h0000;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            a_q    <= in_a;
            b_q    <= in_b;
            res_q  <= '0;
            acc_q  <= 16'h0000;
            beat_q <= '0;
            err_q  <= ~op_legal(in_op);
          end
        end
        ST_RUN: begin
          beat_q <= beat_q + 1'b1;
          if (op_q == OP_VDOT) begin
            acc_q <= chain[LPC];
            if (last_beat) res_q <= {{(W-16){1'b0}}, chain[LPC]};
          end else begin
            for (int k = 0; k < LPC; k++) begin
              res_q[(int'(beat_q) * LPC + k) * 16 +: 16] <= ly[k];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = res_q;
  assign out_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vector_fp16_unit.sv
module tb_vector_fp16_unit;

  localparam int LANES = 16;
  localparam int LPC   = 4;
  localparam int N     = LANES / LPC;
  localparam int W     = LANES * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  vector_fp16_unit #(.LANES(LANES), .LPC(LPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  // All drivers assume they are entered #1 after a rising edge.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_op_ready: in_ready=%b required 1", in_ready);
    end
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the latched operands must not follow.
    in_valid = 1'b0; in_op = 4'b1111; in_a = ~a; in_b = ~b;
  endtask

  task automatic wait_valid(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_timeout: out_valid=%b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 4'd0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_result !== '0)   begin errors++; $display("FAIL reset_out_result: got %h required 0", out_result); end
    checks++;
    if (out_err !== 1'b0)    begin errors++; $display("FAIL reset_out_err: got %b required 0", out_err); end
    checks++;
    if (dbg_state !== 2'd0)  begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vadd();
    int lat; logic rs;
    start_op(4'b0000, fill(16'h3C00), fill(16'h4000));
    wait_valid(lat, rs);
    checks++;
    if (lat != N) begin errors++; $display("FAIL vadd_latency: got %0d edges after accept required %0d", lat, N); end
    checks++;
    if (rs !== 1'b0) begin errors++; $display("FAIL vadd_in_ready_busy: in_ready seen high=%b required 0", rs); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL vadd_in_ready_done: got %b required 0", in_ready); end
    checks++;
    if (out_result !== fill(16'h4200)) begin errors++; $display("FAIL vadd_result: got %h required %h", out_result, fill(16'h4200)); end
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("FAIL vadd_err: got %b required 0", out_err); end
    ack();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL vadd_valid_drop: got %b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL vadd_ready_back: got %b required 1", in_ready); end
  endtask

  task automatic test_smul();
    int lat; logic rs; logic [W-1:0] b;
    b = fill(16'hFFFF);
    b[15:0] = 16'h3800;
    start_op(4'b0010, fill(16'h4000), b);
    wait_valid(lat, rs);
    checks++;
    if (out_result !== fill(16'h3C00)) begin errors++; $display("FAIL smul_result: got %h required %h", out_result, fill(16'h3C00)); end
    ack();
  endtask

  task automatic test_vdot();
    int lat; logic rs; logic [W-1:0] exp_v;
    exp_v = '0;
    exp_v[15:0] = 16'h5000;
    start_op(4'b0001, fill(16'h3C00), fill(16'h4000));
    wait_valid(lat, rs);
    checks++;
    if (lat != N) begin errors++; $display("FAIL vdot_latency: got %0d required %0d", lat, N); end
    checks++;
    if (out_result !== exp_v) begin errors++; $display("FAIL vdot_result: got %h required %h", out_result, exp_v); end
    ack();
  endtask

  task automatic test_special_add();
    int lat; logic rs; logic [W-1:0] a, b, exp_v;
    a = fill(16'h3C00); b = fill(16'h3C00); exp_v = fill(16'h4000);
    a[15:0]  = 16'h7BFF; b[15:0]  = 16'h7BFF; exp_v[15:0]  = 16'h7C00;
    a[31:16] = 16'h7C00; b[31:16] = 16'hFC00; exp_v[31:16] = 16'h7E00;
    a[47:32] = 16'h0001; b[47:32] = 16'h0000; exp_v[47:32] = 16'h0000;
    a[63:48] = 16'h3C00; b[63:48] = 16'hBC00; exp_v[63:48] = 16'h0000;
    a[79:64] = 16'h8000; b[79:64] = 16'h8000; exp_v[79:64] = 16'h8000;
    a[95:80] = 16'h7E00; b[95:80] = 16'h3C00; exp_v[95:80] = 16'h7E00;
    start_op(4'b0000, a, b);
    wait_valid(lat, rs);
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if (out_result[i*16 +: 16] !== exp_v[i*16 +: 16]) begin
        errors++;
        $display("FAIL special_add_lane%0d: got %h required %h", i, out_result[i*16 +: 16], exp_v[i*16 +: 16]);
      end
    end
    ack();
  endtask

  task automatic test_rounding();
    int lat; logic rs; logic [W-1:0] a, exp_v;
    // 1 + 2^-11 is a tie that stays even; 1+2^-10 + 2^-11 is a tie that rounds up.
    a = fill(16'h3C00); exp_v = fill(16'h3C00);
    a[31:16] = 16'h3C01; exp_v[31:16] = 16'h3C02;
    start_op(4'b0000, a, fill(16'h1000));
    wait_valid(lat, rs);
    checks++;
    if (out_result !== exp_v) begin errors++; $display("FAIL rne_result: got %h required %h", out_result, exp_v); end
    ack();
  endtask

  task automatic test_special_mul();
    int lat; logic rs; logic [W-1:0] a, exp_v;
    a = fill(16'h3C00); exp_v = fill(16'h7C00);
    a[15:0] = 16'h0000; exp_v[15:0] = 16'h7E00;
    a[31:16] = 16'hBC00; exp_v[31:16] = 16'hFC00;
    start_op(4'b0010, a, fill(16'h7C00));
    wait_valid(lat, rs);
    checks++;
    if (out_result !== exp_v) begin errors++; $display("FAIL special_mul_result: got %h required %h", out_result, exp_v); end
    ack();
  endtask

  task automatic test_backpressure_illegal();
    int lat; logic rs;
    start_op(4'b0000, fill(16'h4400), fill(16'h4400));
    wait_valid(lat, rs);
    checks++;
    if (out_result !== fill(16'h4800)) begin errors++; $display("FAIL bp_result: got %h required %h", out_result, fill(16'h4800)); end
    // Offer an illegal op while the result is held; it must wait for IDLE.
    in_valid = 1'b1; in_op = 4'b0100; in_a = fill(16'h1234); in_b = fill(16'h5678);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== fill(16'h4800)) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d: valid=%b ready=%b result=%h required 1 0 %h", c, out_valid, in_ready, out_result, fill(16'h4800));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_handshake: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b required 1", out_valid); end
    checks++;
    if (out_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b required 1", out_err); end
    checks++;
    if (out_result !== '0) begin errors++; $display("FAIL illegal_result: got %h required 0", out_result); end
    ack();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic rs; logic seen;
    start_op(4'b0000, fill(16'h4000), fill(16'h4000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL midrst_in_run: state=%0d required 1", dbg_state); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output: out_valid seen=%b required 0", seen); end
    start_op(4'b0000, fill(16'h3800), fill(16'h3800));
    wait_valid(lat, rs);
    checks++;
    if (lat != N) begin errors++; $display("FAIL midrst_next_latency: got %0d required %0d", lat, N); end
    checks++;
    if (out_result !== fill(16'h3C00) || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next_result: got %h err=%b required %h err=0", out_result, out_err, fill(16'h3C00));
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_smul();
    test_vdot();
    test_special_add();
    test_rounding();
    test_special_mul();
    test_backpressure_illegal();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
